// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default or 8E1 when UART_TX_PARITY_EN is defined; frame is 10/11 bit times from accept to tx_done.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight or reset is asserted.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        tx_serial_q;
    logic        tx_ready_q;
    logic        tx_done_q;
`ifdef UART_TX_PARITY_EN
    logic        parity_q;
`endif

    logic        baud_last;
    assign baud_last = (baud_q == BAUD_MAX);

    // Outputs are registered alongside the state so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_q      <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            tx_serial_q <= 1'b1;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q    <= 16'd0;
                    bit_idx_q <= 3'd0;
                    if (tx_valid && tx_ready_q) begin
                        shift_q     <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_q    <= ^tx_data;
`endif
                        state_q     <= START;
                        tx_serial_q <= 1'b0;
                        tx_ready_q  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q      <= 16'd0;
                        state_q     <= DATA;
                        tx_serial_q <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q <= 16'd0;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_q     <= PARITY;
                            tx_serial_q <= parity_q;
`else
                            state_q     <= STOP;
                            tx_serial_q <= 1'b1;
`endif
                        end else begin
                            // Shift right so the next bit to send is always at bit 0.
                            bit_idx_q   <= bit_idx_q + 3'd1;
                            shift_q     <= {1'b0, shift_q[7:1]};
                            tx_serial_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_q      <= 16'd0;
                        state_q     <= STOP;
                        tx_serial_q <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud_q      <= 16'd0;
                        state_q     <= IDLE;
                        tx_serial_q <= 1'b1;
                        tx_ready_q  <= 1'b1;
                        tx_done_q   <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    baud_q      <= 16'd0;
                    bit_idx_q   <= 3'd0;
                    tx_serial_q <= 1'b1;
                    tx_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready  = tx_ready_q;
    assign tx_serial = tx_serial_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLKS_PER_BIT=4; frame length follows UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] d;
        logic       par;
        bit         abort;
        int         gap;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_done;

    int total = 0;
    int bad = 0;
    item_t exp_q[$];
    bit mon_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_serial(tx_serial),
        .tx_done  (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic exp_bit(input item_t it, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return it.d[b-1];
        if (NB == 11 && b == 9) return it.par;
        return 1'b1;
    endfunction

    // Monitor: rst is read at the edge it acts on, outputs at the following negedge.
    initial begin : monitor
        item_t cur;
        int    k;
        int    cyc;
        int    last_stop;
        bit    rst_e;
        bit    bit_err;
        bit    done_err;
        cur = '{d: 8'h00, par: 1'b0, abort: 1'b0, gap: -1};
        k = 0; cyc = 0; last_stop = -1000; bit_err = 0; done_err = 0;
        forever begin
            @(posedge clk);
            rst_e = rst;
            @(negedge clk);
            cyc++;
            if (rst_e) begin
                if (mon_busy) begin
                    check("abort_expected", 32'(cur.abort), 32'd1);
                    mon_busy = 1'b0;
                end
                check("reset_outputs", {29'd0, tx_serial, tx_ready, tx_done}, 32'b110);
            end else if (mon_busy) begin
                if (k < NB*C) begin
                    if (tx_serial !== exp_bit(cur, k / C)) bit_err = 1;
                    if (tx_done !== 1'b0) done_err = 1;
                    if (k % C == 0 && k / C == NB-1) last_stop = cyc;
                    if (k % C == C-1) begin
                        check($sformatf("bit%0d_of_%02h", k / C, cur.d), 32'(bit_err), 32'd0);
                        bit_err = 0;
                    end
                end else begin
                    check($sformatf("done_timing_%02h", cur.d),
                          {29'd0, tx_done, tx_serial, done_err}, 32'b110);
                    mon_busy = 1'b0;
                end
                k++;
            end else if (tx_done === 1'b1) begin
                check("stray_done", 32'(tx_done), 32'd0);
            end else if (tx_serial === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    mon_busy = 1'b1;
                    k = 1; bit_err = 0; done_err = 0;
                    check("ready_low_in_frame", 32'(tx_ready), 32'd0);
                    if (cur.gap >= 0)
                        check("stop_to_start_gap", 32'(cyc - last_stop), 32'(cur.gap));
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic par, input bit abort,
                        input int gap, input bit keep);
        int t;
        t = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            check("ready_timeout", 32'd1, 32'd0);
            tx_valid = 1'b0;
            return;
        end
        exp_q.push_back('{d: d, par: par, abort: abort, gap: gap});
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((mon_busy || exp_q.size() != 0 || tx_ready !== 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(t >= 500), 32'd0);
    endtask

    initial begin : driver
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_serial", 32'(tx_serial), 32'd1);
        check("idle_ready", 32'(tx_ready), 32'd1);

        send(8'h55, 1'b0, 0, -1, 0);
        send(8'h07, 1'b1, 0, -1, 0);
        send(8'h01, 1'b1, 0, -1, 0);
        send(8'h80, 1'b1, 0, -1, 0);
        drain();

        // Back-to-back with tx_valid held: one idle cycle between frames.
        send(8'hA5, 1'b0, 0, -1, 1);
        send(8'h3C, 1'b0, 0, C+1, 0);
        drain();

        // Reset during data bit 3 of 0xF0.
        send(8'hF0, 1'b0, 1, -1, 0);
        repeat (4*C) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(8'hFF, 1'b0, 0, -1, 0);
        drain();

        // Input activity mid-frame must not disturb it or start another.
        send(8'h81, 1'b0, 0, -1, 0);
        repeat (8) @(negedge clk);
        tx_data = 8'h7E; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'hC3;
        drain();
        repeat (3*C*NB) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("monitor_idle", 32'(mon_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
